multicycle_core: RTL and testbench
==================================

MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 SHALL have parameter ADDR_W, default 24: memory address width, legal range 17..24.
REQ-002 SHALL have parameter RESET_PC, default 24'h003C8C: PC value loaded on reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port mem_rdata, input, 16 bits: read data, valid in the cycle mem_req && mem_ready.
REQ-006 SHALL have port mem_ready, input, 1 bit: memory completes the current request this cycle.
REQ-007 SHALL have port mem_req, output, 1 bit: memory request valid.
REQ-008 SHALL have port mem_we, output, 1 bit: request is a write; only meaningful while mem_req=1.
REQ-009 SHALL have port mem_addr, output, ADDR_W bits: request address.
REQ-010 SHALL have port mem_wdata, output, 16 bits: write data.
REQ-011 SHALL have port halted, output, 1 bit: core has stopped fetching.

Function
REQ-012 Instruction word fields SHALL be: op=[15:12], rs=[11:8], rd=[7:4], imm=[7:0], sh=[3:0].
REQ-013 Opcodes SHALL be 0 ADD, 1 ADDI, 2 SUB, 3 LW, 4 SW, 5 LUI, 6 CMP, 7 BR, 8 JMP, 9 SLL, A SLR, B AND, C NAND, D OR, E NOT, F LLI.
REQ-014 ALU results SHALL be as follows, mod 2^16, shifts logical:
- ADD: R[rd] = R[rs]+R[rd]
- SUB: R[rd] = R[rd]-R[rs]
- ADDI: R[rs] = R[rs]+zext(imm)
- SLL/SLR: R[rd] = R[rs]<</>>sh
- AND/NAND/OR: R[rd] = R[rs] op R[rd]
- NOT: R[rd] = ~R[rs]
- LUI: R[rs] = {imm, R[rs][7:0]}
- LLI: R[rs] = {R[rs][15:8], imm}
REQ-015 CMP SHALL set Z=(R[rs]==R[rd]) and N=(R[rs]<R[rd], unsigned), and SHALL write no register.
REQ-016 LW, SW, BR and JMP SHALL be two-word instructions, with target T={imm, word2}[ADDR_W-1:0].
REQ-017 The FSM states SHALL be FETCH, DECODE, EXEC, FETCH2, MEM_RD, MEM_WR and HALT.
REQ-018 In FETCH, FETCH2, MEM_RD and MEM_WR the core SHALL assert mem_req and SHALL hold mem_addr, mem_we and mem_wdata stable until mem_ready=1.
REQ-019 The state SHALL advance only on a cycle with mem_req && mem_ready; any number of wait cycles SHALL be tolerated.
REQ-020 On FETCH completion the core SHALL latch IR, set PC=PC+1 (mod 2^ADDR_W) and go to DECODE.
REQ-021 DECODE SHALL read R[rs] and R[rd], then go to FETCH2 for LW/SW/BR/JMP and to EXEC otherwise.
REQ-022 EXEC SHALL perform the write or flag update and then go to FETCH.
REQ-023 FETCH2 completion SHALL latch word2 and set PC=PC+1, then:
- LW goes to MEM_RD; SW goes to MEM_WR.
- JMP sets PC=T.
- BR sets PC=T if the condition holds, else keeps PC+1.
- BR and JMP then go to FETCH.
REQ-024 BR conditions, selected by rs, SHALL be:
- 0 EQ: Z
- 1 NE: !Z
- 2 LT: N
- 3 LE: Z|N
- 4 GT: !Z&!N
- 5 GE: !N
- 6..F: never taken
REQ-025 MEM_RD SHALL read address T and write mem_rdata to R[rd]; MEM_WR SHALL write R[rs] to address T with mem_we=1.
REQ-026 A JMP whose T equals the address of its own first word SHALL enter HALT.
REQ-027 In HALT, mem_req SHALL be 0 and halted SHALL be 1, until reset.
REQ-028 With mem_ready held at 1, latency SHALL be: ALU/CMP 3 cycles, BR/JMP 3 cycles, LW/SW 4 cycles.
REQ-029 When mem_req=0, mem_we SHALL be 0 and mem_addr and mem_wdata SHALL be 0.
REQ-030 A register write and a read of the same register in the same cycle SHALL return the old value.

Reset
REQ-031 When rst_n=0 the core SHALL immediately set: state=FETCH, PC=RESET_PC, Z=N=0, all 16 registers=0, halted=0, mem_req=0, mem_we=0.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction, with no register or flag update.
REQ-033 The first request after rst_n rises SHALL be a fetch from RESET_PC.

Structure
REQ-034 The opcode, state and branch-condition encodings SHALL reside in shared package core_pkg.
REQ-035 There SHALL be one sub-module, core_regfile: 16x16 storage, 2 asynchronous read ports, 1 synchronous write port, async clear on rst_n.

Verification
REQ-036 The bench SHALL cover reset with mem_ready=1 -> first request mem_addr=0x003C8C, mem_we=0, mem_req=1 on the first clock after release.
REQ-037 The bench SHALL cover LLI R1,0x05; LLI R2,0x03; SUB R1->R2 -> R2=0xFFFE, with each instruction taking 3 cycles.
REQ-038 The bench SHALL cover SW R3=0xBEEF to 0x12_3456, then LW to R4 -> a write beat at 0x123456 with wdata 0xBEEF, then R4=0xBEEF.
REQ-039 The bench SHALL cover mem_ready low for 5 cycles during FETCH2 -> mem_addr stable, no PC change, then completion on the ready cycle.
REQ-040 The bench SHALL cover CMP R1=2,R2=7 then BR LT and BR GE to 0x004000 -> the first branch is taken, and the second falls through to PC+2.
REQ-041 The bench SHALL cover JMP to its own address -> halted=1 and mem_req=0 thereafter; rst_n pulse -> fetch from 0x003C8C resumes.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// core_pkg
// ----------------------------------------------------------------------------
// Shared encodings for the multicycle core: opcodes, FSM states and branch
// conditions, plus small decode helpers used by the top level.
// Revision: 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREGS  = 16;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_ADDI = 4'h1,
    OP_SUB  = 4'h2,
    OP_LW   = 4'h3,
    OP_SW   = 4'h4,
    OP_LUI  = 4'h5,
    OP_CMP  = 4'h6,
    OP_BR   = 4'h7,
    OP_JMP  = 4'h8,
    OP_SLL  = 4'h9,
    OP_SLR  = 4'hA,
    OP_AND  = 4'hB,
    OP_NAND = 4'hC,
    OP_OR   = 4'hD,
    OP_NOT  = 4'hE,
    OP_LLI  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_FETCH2 = 3'd3,
    ST_MEM_RD = 3'd4,
    ST_MEM_WR = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    BR_EQ = 4'h0,
    BR_NE = 4'h1,
    BR_LT = 4'h2,
    BR_LE = 4'h3,
    BR_GT = 4'h4,
    BR_GE = 4'h5
  } brcond_e;

  // LW, SW, BR and JMP carry a second word holding the low target bits.
  function automatic logic is_two_word(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_BR) || (op == OP_JMP);
  endfunction

  // Condition codes 6..F are reserved and never taken.
  function automatic logic br_taken(input logic [3:0] cond, input logic z, input logic n);
    logic t;
    case (cond)
      BR_EQ:   t = z;
      BR_NE:   t = !z;
      BR_LT:   t = n;
      BR_LE:   t = z | n;
      BR_GT:   t = !z & !n;
      BR_GE:   t = !n;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_regfile.sv
`default_nettype none
// ============================================================================
// core_regfile
// ----------------------------------------------------------------------------
// 16 x 16-bit register file: two asynchronous read ports, one synchronous
// write port, asynchronous clear. A read of the register being written in
// the same cycle returns the old contents.
//   clk, rst_n            : clock, asynchronous active-low clear
//   ra_i / rdata_a_o      : read port A
//   rb_i / rdata_b_o      : read port B
//   we_i, waddr_i, wdata_i: write port
// Revision: 1.0 - initial release
// ============================================================================
module core_regfile
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        ra_i,
  input  logic [3:0]        rb_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic              we_i,
  input  logic [3:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[ra_i];
  assign rdata_b_o = regs_q[rb_i];

endmodule
`default_nettype wire

// File: rtl/multicycle_core.sv
`default_nettype none
// ============================================================================
// multicycle_core
// ----------------------------------------------------------------------------
// 16-bit multicycle processor with a single shared memory port.
//   clk, rst_n    : clock, asynchronous active-low reset
//   mem_rdata     : read data, valid when mem_req && mem_ready
//   mem_ready     : memory completes the current request
//   mem_req       : request valid
//   mem_we        : request is a write
//   mem_addr      : request address (ADDR_W bits)
//   mem_wdata     : write data
//   halted        : core stopped after a self-jump
// Revision: 1.0 - initial release
// ============================================================================
module multicycle_core
  import core_pkg::*;
#(
  parameter int unsigned ADDR_W   = 24,
  parameter logic [23:0] RESET_PC = 24'h003C8C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              halted
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ia_q, ia_d;       // address of the current first word
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] w2_q, w2_d;
  logic [DATA_W-1:0] a_q, a_d;         // R[rs] captured in DECODE
  logic [DATA_W-1:0] b_q, b_d;         // R[rd] captured in DECODE
  logic              z_q, z_d;
  logic              n_q, n_d;

  opcode_e     op;
  logic [3:0]  rs, rd, sh;
  logic [7:0]  imm;

  assign op  = opcode_e'(ir_q[15:12]);
  assign rs  = ir_q[11:8];
  assign rd  = ir_q[7:4];
  assign imm = ir_q[7:0];
  assign sh  = ir_q[3:0];

  // Target of a two-word instruction. In FETCH2 the second word is still on
  // the read bus; once latched it is taken from w2_q.
  logic [23:0]       tgt_f2_full, tgt_mem_full;
  logic [ADDR_W-1:0] tgt_f2, tgt_mem;

  assign tgt_f2_full  = {imm, mem_rdata};
  assign tgt_mem_full = {imm, w2_q};
  assign tgt_f2       = tgt_f2_full[ADDR_W-1:0];
  assign tgt_mem      = tgt_mem_full[ADDR_W-1:0];

  logic bus_state;
  logic xfer;

  assign bus_state = (state_q == ST_FETCH) || (state_q == ST_FETCH2) ||
                     (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
  assign xfer      = bus_state && mem_ready;

  logic              rf_we;
  logic [3:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b;

  core_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra_i      (rs),
    .rb_i      (rd),
    .rdata_a_o (rf_rdata_a),
    .rdata_b_o (rf_rdata_b),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH:  if (xfer) state_d = ST_DECODE;
      ST_DECODE: state_d = is_two_word(op) ? ST_FETCH2 : ST_EXEC;
      ST_EXEC:   state_d = ST_FETCH;
      ST_FETCH2: begin
        if (xfer) begin
          case (op)
            OP_LW:   state_d = ST_MEM_RD;
            OP_SW:   state_d = ST_MEM_WR;
            OP_JMP:  state_d = (tgt_f2 == ia_q) ? ST_HALT : ST_FETCH;
            default: state_d = ST_FETCH;
          endcase
        end
      end
      ST_MEM_RD, ST_MEM_WR: if (xfer) state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. The bus is forced idle while reset is held, since the
  // state register already reads FETCH during reset.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    halted    = (state_q == ST_HALT);
    if (rst_n) begin
      case (state_q)
        ST_FETCH, ST_FETCH2: begin
          mem_req  = 1'b1;
          mem_addr = pc_q;
        end
        ST_MEM_RD: begin
          mem_req  = 1'b1;
          mem_addr = tgt_mem;
        end
        ST_MEM_WR: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = tgt_mem;
          mem_wdata = a_q;
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath next-state and register-file write
  // --------------------------------------------------------------------------
  always_comb begin
    pc_d     = pc_q;
    ia_d     = ia_q;
    ir_d     = ir_q;
    w2_d     = w2_q;
    a_d      = a_q;
    b_d      = b_q;
    z_d      = z_q;
    n_d      = n_q;
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = '0;

    case (state_q)
      ST_FETCH: begin
        if (xfer) begin
          ir_d = mem_rdata;
          ia_d = pc_q;
          pc_d = pc_q + ADDR_W'(1);
        end
      end

      ST_DECODE: begin
        a_d = rf_rdata_a;
        b_d = rf_rdata_b;
      end

      ST_EXEC: begin
        rf_we = 1'b1;
        case (op)
          OP_ADD:  rf_wdata = a_q + b_q;
          OP_SUB:  rf_wdata = b_q - a_q;
          OP_ADDI: begin rf_waddr = rs; rf_wdata = a_q + {8'h00, imm}; end
          OP_SLL:  rf_wdata = a_q << sh;
          OP_SLR:  rf_wdata = a_q >> sh;
          OP_AND:  rf_wdata = a_q & b_q;
          OP_NAND: rf_wdata = ~(a_q & b_q);
          OP_OR:   rf_wdata = a_q | b_q;
          OP_NOT:  rf_wdata = ~a_q;
          OP_LUI:  begin rf_waddr = rs; rf_wdata = {imm, a_q[7:0]}; end
          OP_LLI:  begin rf_waddr = rs; rf_wdata = {a_q[15:8], imm}; end
          OP_CMP:  begin
            rf_we = 1'b0;
            z_d   = (a_q == b_q);
            n_d   = (a_q < b_q);
          end
          default: rf_we = 1'b0;
        endcase
      end

      ST_FETCH2: begin
        if (xfer) begin
          w2_d = mem_rdata;
          pc_d = pc_q + ADDR_W'(1);
          if (op == OP_JMP) begin
            pc_d = tgt_f2;
          end else if ((op == OP_BR) && br_taken(rs, z_q, n_q)) begin
            pc_d = tgt_f2;
          end
        end
      end

      ST_MEM_RD: begin
        if (xfer) begin
          rf_we    = 1'b1;
          rf_wdata = mem_rdata;
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC[ADDR_W-1:0];
      ia_q <= '0;
      ir_q <= '0;
      w2_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      z_q  <= 1'b0;
      n_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ia_q <= ia_d;
      ir_q <= ir_d;
      w2_q <= w2_d;
      a_q  <= a_d;
      b_q  <= b_d;
      z_q  <= z_d;
      n_q  <= n_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_core.sv
`default_nettype none
// ============================================================================
// tb_multicycle_core
// ----------------------------------------------------------------------------
// Self-checking bench: an instruction-level reference model predicts every
// memory beat (address, direction, write data) the core must issue; a
// memory responder with random or directed wait states serves the core.
// Revision: 1.0 - initial release
// ============================================================================
module tb_multicycle_core;

  localparam int unsigned ADDR_W   = 24;
  localparam logic [23:0] RESET_PC = 24'h003C8C;

  localparam int K_F1   = 0;
  localparam int K_F2   = 1;
  localparam int K_DATA = 2;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_ready = 1'b1;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        halted;

  multicycle_core #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Memory: sparse array; unwritten locations return an address hash.
  // --------------------------------------------------------------------------
  logic [15:0] mem [int unsigned];
  int unsigned pw;

  function automatic logic [15:0] mem_rd(input logic [23:0] a);
    if (mem.exists(32'(a))) return mem[32'(a)];
    return a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic emit(input logic [15:0] w);
    mem[pw] = w;
    pw++;
  endtask

  // --------------------------------------------------------------------------
  // Instruction-level reference model
  // --------------------------------------------------------------------------
  typedef struct {
    int          kind;
    logic [23:0] addr;
    logic        we;
    logic [15:0] wdata;
  } beat_t;

  beat_t       expq[$];
  logic [15:0] m_r [16];
  logic [23:0] m_pc;
  logic        m_z, m_n, m_halt;
  int          m_lat;

  function automatic logic cond_holds(input logic [3:0] c, input logic z, input logic n);
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return n;
      4'd3:    return z || n;
      4'd4:    return !z && !n;
      4'd5:    return !n;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = 16'h0;
    m_pc   = RESET_PC;
    m_z    = 1'b0;
    m_n    = 1'b0;
    m_halt = 1'b0;
    m_lat  = 0;
    expq.delete();
  endtask

  task automatic model_step();
    logic [23:0] pc0, tgt;
    logic [15:0] w1, w2, a, b;
    logic [3:0]  op, rs, rd, sh;
    logic [7:0]  imm;
    pc0 = m_pc;
    w1  = mem_rd(pc0);
    expq.push_back('{K_F1, pc0, 1'b0, 16'h0});
    m_pc = pc0 + 24'd1;
    op  = w1[15:12]; rs = w1[11:8]; rd = w1[7:4]; imm = w1[7:0]; sh = w1[3:0];
    a   = m_r[rs];
    b   = m_r[rd];
    m_lat = 3;
    if (op == 4'h3 || op == 4'h4 || op == 4'h7 || op == 4'h8) begin
      w2 = mem_rd(m_pc);
      expq.push_back('{K_F2, m_pc, 1'b0, 16'h0});
      m_pc = m_pc + 24'd1;
      tgt  = {imm, w2};
      case (op)
        4'h3: begin
          expq.push_back('{K_DATA, tgt, 1'b0, 16'h0});
          m_r[rd] = mem_rd(tgt);
          m_lat = 4;
        end
        4'h4: begin
          expq.push_back('{K_DATA, tgt, 1'b1, a});
          m_lat = 4;
        end
        4'h7: if (cond_holds(rs, m_z, m_n)) m_pc = tgt;
        default: begin
          if (tgt == pc0) m_halt = 1'b1;
          else            m_pc = tgt;
        end
      endcase
    end else begin
      case (op)
        4'h0: m_r[rd] = a + b;
        4'h1: m_r[rs] = a + {8'h00, imm};
        4'h2: m_r[rd] = b - a;
        4'h5: m_r[rs] = {imm, a[7:0]};
        4'h6: begin m_z = (a == b); m_n = (a < b); end
        4'h9: m_r[rd] = a << sh;
        4'hA: m_r[rd] = a >> sh;
        4'hB: m_r[rd] = a & b;
        4'hC: m_r[rd] = ~(a & b);
        4'hD: m_r[rd] = a | b;
        4'hE: m_r[rd] = ~a;
        default: m_r[rs] = {a[15:8], imm};
      endcase
    end
  endtask

  // --------------------------------------------------------------------------
  // Reset and run
  // --------------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    #1;
    check_eq("rst_req",    32'(mem_req), 32'd0);
    check_eq("rst_we",     32'(mem_we),  32'd0);
    check_eq("rst_halted", 32'(halted),  32'd0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b0;
  endtask

  // mode 0: mem_ready always 1; mode 1: random wait states
  task automatic run_prog(input int mode, input bit stall_f2, input bit chk_lat, input string name);
    int    cyc, last_f1, prev_lat, stall_cnt;
    bit    stall_pend;
    beat_t e;
    do_reset();
    model_reset();
    cyc        = 0;
    last_f1    = -1;
    prev_lat   = 0;
    stall_cnt  = 0;
    stall_pend = stall_f2;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc > 4000) begin
        check_eq({name, "_timeout"}, 32'd0, 32'd1);
        break;
      end
      if (cyc == 1) begin
        check_eq("first_req",  32'(mem_req),  32'd1);
        check_eq("first_addr", 32'(mem_addr), 32'(RESET_PC));
        check_eq("first_we",   32'(mem_we),   32'd0);
      end
      if (expq.size() == 0 && !m_halt) begin
        prev_lat = m_lat;
        model_step();
      end
      if (expq.size() == 0) begin
        for (int i = 0; i < 8; i++) begin
          check_eq({name, "_halted"},   32'(halted),  32'd1);
          check_eq({name, "_halt_req"}, 32'(mem_req), 32'd0);
          if (i < 7) @(negedge clk);
        end
        break;
      end
      e = expq[0];
      if (stall_pend && e.kind == K_F2 && mem_req) begin
        if (stall_cnt < 5) begin
          mem_ready = 1'b0;
          check_eq("stall_req",  32'(mem_req),  32'd1);
          check_eq("stall_addr", 32'(mem_addr), 32'(e.addr));
          check_eq("stall_we",   32'(mem_we),   32'd0);
          stall_cnt++;
        end else begin
          mem_ready  = 1'b1;
          stall_pend = 1'b0;
        end
      end else if (mode == 0) begin
        mem_ready = 1'b1;
      end else begin
        mem_ready = ($urandom_range(0, 3) != 0);
      end
      mem_rdata = mem_req ? mem_rd(mem_addr) : 16'h0;
      if (mem_req && mem_ready) begin
        void'(expq.pop_front());
        check_eq({name, "_addr"}, 32'(mem_addr), 32'(e.addr));
        check_eq({name, "_we"},   32'(mem_we),   32'(e.we));
        if (e.we) begin
          check_eq({name, "_wdata"}, 32'(mem_wdata), 32'(e.wdata));
          mem[32'(mem_addr)] = mem_wdata;
        end
        if (chk_lat && e.kind == K_F1) begin
          if (last_f1 >= 0) check_eq({name, "_latency"}, 32'(cyc - last_f1), 32'(prev_lat));
          last_f1 = cyc;
        end
      end else if (!mem_req) begin
        check_eq("idle_bus",   {7'h0, mem_we, mem_addr}, 32'd0);
        check_eq("idle_wdata", 32'(mem_wdata), 32'd0);
        check_eq("run_halted", 32'(halted),    32'd0);
      end
    end
    if (stall_f2) check_eq("stall_done", 32'(stall_cnt), 32'd5);
  endtask

  // --------------------------------------------------------------------------
  // Random program generator
  // --------------------------------------------------------------------------
  logic [3:0] alu_ops [11] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

  function automatic logic [15:0] alu_word();
    return {alu_ops[$urandom_range(0, 10)], 12'($urandom)};
  endfunction

  task automatic gen_random_prog(input int n);
    logic [23:0] tgt;
    mem.delete();
    pw = 32'(RESET_PC);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: emit(alu_word());
        5: emit({4'h6, 12'($urandom)});
        6: begin
          emit({4'h4, 4'($urandom), 8'($urandom_range(16, 255))});
          emit(16'($urandom));
        end
        7: begin
          emit({4'h3, 12'($urandom)});
          emit(16'($urandom));
        end
        default: begin
          tgt = 24'(pw + 4);
          emit({4'h7, 4'($urandom_range(0, 7)), tgt[23:16]});
          emit(tgt[15:0]);
          emit(alu_word());
          emit(alu_word());
        end
      endcase
    end
    for (int r = 0; r < 16; r++) begin
      emit({4'h4, 4'(r), 8'h20});
      emit(16'(r));
    end
    tgt = 24'(pw);
    emit({8'h80, tgt[23:16]});
    emit(tgt[15:0]);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    // Directed: ALU chain, SW/LW round trip, CMP + branches, self-jump halt
    mem.delete();
    pw = 32'(RESET_PC);
    emit(16'hF105);                   // LLI R1,0x05
    emit(16'hF203);                   // LLI R2,0x03
    emit(16'h2120);                   // SUB R2 = R2 - R1
    emit(16'h4210); emit(16'h0000);   // SW  R2 -> 0x100000
    emit(16'hF3EF);                   // LLI R3,0xEF
    emit(16'h53BE);                   // LUI R3,0xBE
    emit(16'h4312); emit(16'h3456);   // SW  R3 -> 0x123456
    emit(16'h3312); emit(16'h3456);   // LW  R1 <- 0x123456
    emit(16'hD140);                   // OR  R4 = R1 | R4
    emit(16'h4410); emit(16'h0001);   // SW  R4 -> 0x100001
    emit(16'hF102); emit(16'h5100);   // R1 = 2
    emit(16'hF207); emit(16'h5200);   // R2 = 7
    emit(16'h6120);                   // CMP R1,R2
    emit(16'h7200); emit(16'h4000);   // BR LT -> 0x004000 (taken)
    pw = 32'h4000;
    emit(16'h7500); emit(16'h4000);   // BR GE -> 0x004000 (not taken)
    emit(16'h8000); emit(16'h4002);   // JMP self -> halt
    run_prog(0, 1'b0, 1'b1, "dirA");
    check_eq("sub_result", 32'(mem_rd(24'h100000)), 32'h0000FFFE);
    check_eq("sw_beef",    32'(mem_rd(24'h123456)), 32'h0000BEEF);
    check_eq("lw_r4",      32'(mem_rd(24'h100001)), 32'h0000BEEF);

    // Directed: 5 wait cycles on the FETCH2 beat of a SW; run also proves
    // fetching resumes from RESET_PC after the previous halt.
    mem.delete();
    pw = 32'(RESET_PC);
    emit(16'hF511);                   // LLI R5,0x11
    emit(16'h4510); emit(16'h0010);   // SW  R5 -> 0x100010
    emit(16'h8000); emit(16'h3C8F);   // JMP self
    run_prog(0, 1'b1, 1'b0, "dirB");
    check_eq("stall_sw", 32'(mem_rd(24'h100010)), 32'h00000011);

    // Random programs: one with zero wait states and latency checks,
    // the rest with random wait states.
    gen_random_prog(40);
    run_prog(0, 1'b0, 1'b1, "rnd0");
    for (int k = 0; k < 4; k++) begin
      gen_random_prog(40);
      run_prog(1, 1'b0, 1'b0, "rndw");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
